// File: rtl/sram_req_arbiter_if.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter_if
//   One SRAM-like request/response port: address phase (req/addr_ok) and
//   in-order data phase (data_ok/rdata).
//   master modport: the side that issues requests (drives req and payload).
//   slave  modport: the side that accepts requests (drives addr_ok/data_ok/rdata).
// Signals
//   req      1   request valid, held until addr_ok
//   wr       1   write request
//   size     2   0=byte 1=half 2=word
//   wstrb    4   byte strobes
//   addr     32  request address
//   wdata    32  write data
//   addr_ok  1   request accepted this cycle
//   data_ok  1   response valid this cycle
//   rdata    32  read data
// ---------------------------------------------------------------------------
interface sram_req_arbiter_if;
  logic        req;
  logic        wr;
  logic [1:0]  size;
  logic [3:0]  wstrb;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        addr_ok;
  logic        data_ok;
  logic [31:0] rdata;

  modport master (
    output req, wr, size, wstrb, addr, wdata,
    input  addr_ok, data_ok, rdata
  );

  modport slave (
    input  req, wr, size, wstrb, addr, wdata,
    output addr_ok, data_ok, rdata
  );
endinterface

// File: rtl/sram_req_arbiter.sv
// ---------------------------------------------------------------------------
// sram_req_arbiter
//   Shares one SRAM-like slave port between the instruction-fetch requester
//   and the data (load/store) requester. Address-phase requests are
//   arbitrated with data winning ties; the owner of each accepted request is
//   queued so that in-order slave responses are steered back to the right
//   requester with zero latency.
// Parameters
//   MAX_OUT   max accepted-but-unanswered requests (owner queue depth, 1..8)
// Ports
//   clk       in   clock, all state updates on rising edge
//   resetn    in   synchronous reset, active low
//   inst      slave  instruction-fetch requester port
//   data      slave  data requester port
//   s         master shared downstream slave port
//   resp_err  out  sticky: slave response seen with nothing outstanding
// ---------------------------------------------------------------------------
module sram_req_arbiter #(
  parameter int MAX_OUT = 2
) (
  input  logic               clk,
  input  logic               resetn,
  sram_req_arbiter_if.slave  inst,
  sram_req_arbiter_if.slave  data,
  sram_req_arbiter_if.master s,
  output logic               resp_err
);

  localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int CNT_W = $clog2(MAX_OUT + 1);
  localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(MAX_OUT - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUT);

  // The locked states remember which requester holds the slave request
  // while the slave is stalling it, so the request stays stable.
  typedef enum logic [1:0] {
    UNLOCKED    = 2'd0,
    LOCKED_INST = 2'd1,
    LOCKED_DATA = 2'd2
  } lock_state_t;

  lock_state_t lock_reg, lock_next;

  logic [PTR_W-1:0]   wr_ptr_reg, wr_ptr_next;
  logic [PTR_W-1:0]   rd_ptr_reg, rd_ptr_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic [MAX_OUT-1:0] owner_reg, owner_next;  // 1 = DATA owns that slot
  logic [MAX_OUT-1:0] head_sel;
  logic               resp_err_reg, resp_err_next;

  logic grant_inst;
  logic grant_data;
  logic full;
  logic has_out;
  logic s_req_int;
  logic handshake;
  logic push;
  logic pop;
  logic head_is_data;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  // -------------------------------------------------------------------------
  // Grant: a stalled owner keeps the port as long as it still requests;
  // otherwise data has priority over instruction fetch.
  // -------------------------------------------------------------------------
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (lock_reg == LOCKED_INST && inst.req) begin
      grant_inst = 1'b1;
    end else if (lock_reg == LOCKED_DATA && data.req) begin
      grant_data = 1'b1;
    end else if (data.req) begin
      grant_data = 1'b1;
    end else if (inst.req) begin
      grant_inst = 1'b1;
    end
  end

  // Full uses the registered count: a response arriving this cycle does
  // not free a slot until the next one.
  assign full      = (count_reg == CNT_FULL);
  assign has_out   = (count_reg != '0);
  assign s_req_int = (grant_inst | grant_data) & ~full;
  assign handshake = s_req_int & s.addr_ok;
  assign push      = handshake;
  assign pop       = s.data_ok & has_out;

  // -------------------------------------------------------------------------
  // Slave request payload, muxed from the winner; zero when nobody wins.
  // -------------------------------------------------------------------------
  always_comb begin
    s.req   = s_req_int;
    s.wr    = 1'b0;
    s.size  = 2'd0;
    s.wstrb = 4'd0;
    s.addr  = 32'd0;
    s.wdata = 32'd0;
    if (grant_data) begin
      s.wr    = data.wr;
      s.size  = data.size;
      s.wstrb = data.wstrb;
      s.addr  = data.addr;
      s.wdata = data.wdata;
    end else if (grant_inst) begin
      s.wr    = inst.wr;
      s.size  = inst.size;
      s.wstrb = inst.wstrb;
      s.addr  = inst.addr;
      s.wdata = inst.wdata;
    end
  end

  assign inst.addr_ok = grant_inst & handshake;
  assign data.addr_ok = grant_data & handshake;

  // -------------------------------------------------------------------------
  // Owner queue storage: one bit per slot, written at the write pointer on
  // an address handshake; the head bit is selected by the read pointer.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < MAX_OUT; gi++) begin : g_owner
      assign owner_next[gi] = (push && (wr_ptr_reg == PTR_W'(gi))) ? grant_data
                                                                    : owner_reg[gi];
      assign head_sel[gi]   = owner_reg[gi] & (rd_ptr_reg == PTR_W'(gi));
    end
  endgenerate

  assign head_is_data = |head_sel;

  // -------------------------------------------------------------------------
  // Response routing: zero latency, both rdata buses follow the slave.
  // -------------------------------------------------------------------------
  assign inst.data_ok = pop & ~head_is_data;
  assign data.data_ok = pop & head_is_data;
  assign inst.rdata   = s.rdata;
  assign data.rdata   = s.rdata;

  // -------------------------------------------------------------------------
  // Lock FSM next state
  // -------------------------------------------------------------------------
  always_comb begin
    lock_next = lock_reg;
    case (lock_reg)
      UNLOCKED: begin
        if (s_req_int && !s.addr_ok) begin
          lock_next = grant_data ? LOCKED_DATA : LOCKED_INST;
        end
      end
      LOCKED_INST: begin
        if (handshake || !inst.req) begin
          lock_next = UNLOCKED;
        end
      end
      LOCKED_DATA: begin
        if (handshake || !data.req) begin
          lock_next = UNLOCKED;
        end
      end
      default: lock_next = UNLOCKED;
    endcase
  end

  // -------------------------------------------------------------------------
  // Queue pointer / occupancy / error next state
  // -------------------------------------------------------------------------
  always_comb begin
    wr_ptr_next   = push ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
    rd_ptr_next   = pop  ? ptr_inc(rd_ptr_reg) : rd_ptr_reg;
    count_next    = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + 1'b1;
      2'b01:   count_next = count_reg - 1'b1;
      default: count_next = count_reg;
    endcase
    // A response with nothing outstanding is dropped and flagged.
    resp_err_next = resp_err_reg | (s.data_ok & ~has_out);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      lock_reg     <= UNLOCKED;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      owner_reg    <= '0;
      resp_err_reg <= 1'b0;
    end else begin
      lock_reg     <= lock_next;
      wr_ptr_reg   <= wr_ptr_next;
      rd_ptr_reg   <= rd_ptr_next;
      count_reg    <= count_next;
      owner_reg    <= owner_next;
      resp_err_reg <= resp_err_next;
    end
  end

  assign resp_err = resp_err_reg;

endmodule
